cnt_var_bank: RTL and testbench
===============================

# cnt_var_bank

Bank of `NCH` independent variable-modulus counters. It is the parametrised successor to the single up/down counter used for UART baud and bit timing. Each channel adds the following over the single counter:
- runtime direction;
- count enable;
- shadowed modulus reload that takes effect at wrap;
- one-shot mode;
- registered terminal-count pulse.

An optional cascade lets channel i advance only on channel i‑1's wrap, for baud→bit→frame chains.

## Interface
- `NCH`, 2, number of channels (≥1)
- `WIDTH`, 16, counter and modulus width per channel
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  NCH  per-channel count enable
- `dir`  in  NCH  0 = count up, 1 = count down
- `oneshot`  in  NCH  1 = stop after first terminal step
- `max_value`  in  NCH*WIDTH  modulus M; channel i at `[i*WIDTH +: WIDTH]`
- `max_wr`  in  NCH  strobe: capture the `max_value` slice into the shadow register
- `restart`  in  NCH  reload the start value, clear `done`
- `cascade`  in  NCH  1 = channel i steps only on channel i‑1's terminal step (bit 0 ignored)
- `cnt_value`  out  NCH*WIDTH  current count, same slicing as `max_value`
- `tc`  out  NCH  one-cycle pulse, registered, marks a terminal step
- `done`  out  NCH  sticky one-shot completion flag

## Operation
- Per channel, the state is: `cnt`, `act_max`, `shadow`, `pend`, `tc`, `done`.
- Terminal value T = (act_max==0) ? 0 : act_max‑1.
  - Up: start value 0, terminal when cnt ≥ T.
  - Down: start value T, terminal when cnt == 0.
  - M of 0 or 1 gives cnt held at 0 with `tc` on every step.
- `step` = en & ~done (& cascade qualifier, see Configuration).
- `term_step` = step & at-terminal.
- Priority per channel each cycle is rst > restart > step > hold.
- rst: all outputs and internal state go to 0.
  - `cnt_value`=0, `tc`=0, `done`=0.
  - `act_max`=0, `shadow`=0, `pend`=0.
- `max_wr` alone: shadow ← slice, pend ← 1. The running count is not disturbed.
- restart: act_max ← (max_wr ? slice : pend ? shadow : act_max), pend ← 0.
  - cnt ← start value for the new act_max and current `dir`.
  - done ← 0, tc ← 0.
- Step, not terminal: cnt ± 1 according to `dir`.
- term_step, oneshot=0: tc ← 1.
  - act_max ← (max_wr ? slice : pend ? shadow : act_max), pend ← 0.
  - cnt ← start value for that modulus.
- term_step, oneshot=1: tc ← 1, done ← 1, cnt holds the terminal value.
  - The shadow stays pending until restart.
- `max_wr` in the same cycle as a wrap or restart is write-through: the new slice is used immediately and `pend` ends at 0.
- A `dir` change mid-count continues from the current cnt in the new direction. The terminal test always uses the current `dir`.
- `en` low freezes cnt. `tc` still clears the next cycle.
- All arithmetic is modulo 2^WIDTH. M = 2^WIDTH is not expressible; the maximum period is 2^WIDTH‑1.

## Timing
- All outputs are registered. `cnt_value` updates on the edge following a qualifying step.
- `tc` is high for exactly one cycle. That cycle is the one in which `cnt_value` first shows the post-wrap value (oneshot: the held terminal value).
- Up count with M=N has a period of N steps and `tc` once per period.
- restart latency: 1 cycle to the start value. `done` and `tc` are low in that same cycle.
- The shadow takes effect from the first count after the next wrap or restart, never mid-period.

## Configuration
- `CNT_CASCADE_EN` defined:
  - for i≥1 with cascade[i]=1, step[i] additionally requires term_step[i‑1] in the same cycle (combinational);
  - both channels therefore wrap on the same edge;
  - the chain may ripple through all NCH channels.
- `CNT_CASCADE_EN` undefined: the `cascade` port is present but ignored, and all channels are independent.

## Test plan
- Reset, then ch0 M=5 up, en=1: `cnt_value` goes 0,1,2,3,4,0…, with `tc` high in each cycle where cnt=0 after a 4.
- ch1 M=4 down: `cnt_value` goes 3,2,1,0,3…, with `tc` in the cycle showing 3 after 0. Flip `dir` at cnt=2: the sequence continues 3 then wraps at ≥3 to 0.
- ch0 M=5 running, `max_wr` of 3 at cnt=1: the count continues 2,3,4, wraps to 0, then goes 0,1,2,0.
- oneshot=1, M=3 up: the count goes 0,1,2, then `tc` pulses once, `done`=1 and cnt holds at 2. restart then gives cnt=0 and done=0 next cycle.
- restart plus `max_wr`=7 in the same cycle while counting: next cycle cnt=0, act M=7, `pend`=0. rst asserted mid-count clears everything the next cycle.
- With `CNT_CASCADE_EN`, ch0 M=3 and ch1 M=4 cascade: ch1 `tc` every 12 cycles, coincident with ch0's `tc`. Without the macro, ch1 counts every cycle.

Source files
------------

// File: rtl/cnt_var_bank_if.sv
// Purpose : control/status bundle for the cnt_var_bank counter channels.
// Latency : wires only; every timing property belongs to the counter bank.
// Backpressure: none; strobes are sampled on every clock edge.
//
// Ports (all NCH wide unless noted):
//   en, dir, oneshot, max_wr, restart, cascade : control from the master
//   max_value (NCH*WIDTH)                      : modulus slices from the master
//   cnt_value (NCH*WIDTH), tc, done            : status back to the master
// NCH and WIDTH must match the parameters of the cnt_var_bank it connects to.
interface cnt_var_bank_if #(
    parameter int NCH   = 2,
    parameter int WIDTH = 16
);
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       dir;
    logic [NCH-1:0]       oneshot;
    logic [NCH*WIDTH-1:0] max_value;
    logic [NCH-1:0]       max_wr;
    logic [NCH-1:0]       restart;
    logic [NCH-1:0]       cascade;
    logic [NCH*WIDTH-1:0] cnt_value;
    logic [NCH-1:0]       tc;
    logic [NCH-1:0]       done;

    modport master (
        output en, dir, oneshot, max_value, max_wr, restart, cascade,
        input  cnt_value, tc, done
    );

    modport slave (
        input  en, dir, oneshot, max_value, max_wr, restart, cascade,
        output cnt_value, tc, done
    );
endinterface

// File: rtl/cnt_var_bank.sv
// Purpose : bank of NCH independent variable-modulus up/down counters.
// Latency : all outputs registered; cnt_value/tc/done change 1 cycle after the qualifying input.
// Backpressure: none; en gates counting, a frozen channel simply holds its count.
//
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : cnt_var_bank_if.slave (en, dir, oneshot, max_value, max_wr,
//              restart, cascade in; cnt_value, tc, done out)
// Build option: define CNT_CASCADE_EN to let channel i (i>=1, cascade[i]=1)
// advance only on the cycle channel i-1 takes its terminal step. Without the
// macro the cascade inputs are ignored.
module cnt_var_bank #(
    parameter int NCH   = 2,
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    cnt_var_bank_if.slave bus
);

    // Per-channel architectural state.
    logic [WIDTH-1:0] cnt_q    [NCH];
    logic [WIDTH-1:0] act_q    [NCH];   // modulus in force for the current period
    logic [WIDTH-1:0] shadow_q [NCH];   // modulus waiting for the next wrap/restart
    logic [NCH-1:0]   pend_q;
    logic [NCH-1:0]   tc_q;
    logic [NCH-1:0]   done_q;

    // Per-channel combinational helpers.
    logic [WIDTH-1:0] slice      [NCH];
    logic [WIDTH-1:0] term_val   [NCH];
    logic [WIDTH-1:0] next_max   [NCH];
    logic [WIDTH-1:0] next_start [NCH];
    logic [NCH-1:0]   at_term;
    logic [NCH-1:0]   step;
    logic [NCH-1:0]   term_step;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            slice[i] = bus.max_value[i*WIDTH +: WIDTH];

            // M of 0 or 1 both collapse to a single-state counter at 0.
            term_val[i] = (act_q[i] == '0) ? '0 : act_q[i] - 1'b1;

            // Up uses >= so a count left above the terminal value by a
            // direction flip or a smaller modulus still wraps promptly.
            at_term[i] = bus.dir[i] ? (cnt_q[i] == '0) : (cnt_q[i] >= term_val[i]);

            // Modulus for the period that starts at a wrap or restart: a
            // same-cycle write goes straight through, otherwise a pending
            // shadow wins over the current modulus.
            next_max[i] = bus.max_wr[i] ? slice[i] :
                          (pend_q[i] ? shadow_q[i] : act_q[i]);

            // Start value depends on the direction in force this cycle.
            if (bus.dir[i]) begin
                next_start[i] = (next_max[i] == '0) ? '0 : next_max[i] - 1'b1;
            end else begin
                next_start[i] = '0;
            end
        end
    end

    // Step qualification. With cascading, channel i's step depends on the
    // terminal step of channel i-1 in the same cycle, so the chain ripples
    // combinationally from channel 0 upward.
    always_comb begin
`ifdef CNT_CASCADE_EN
        logic prev_term;
        prev_term = 1'b0;
`endif
        step      = '0;
        term_step = '0;
        for (int i = 0; i < NCH; i++) begin
            step[i] = bus.en[i] & ~done_q[i];
`ifdef CNT_CASCADE_EN
            if ((i > 0) && bus.cascade[i]) begin
                step[i] = step[i] & prev_term;
            end
`endif
            term_step[i] = step[i] & at_term[i];
`ifdef CNT_CASCADE_EN
            prev_term = term_step[i];
`endif
        end
    end

`ifdef CNT_CASCADE_EN
    // Channel 0 has no upstream neighbour.
    logic unused_cascade;
    assign unused_cascade = bus.cascade[0];
`else
    logic unused_cascade;
    assign unused_cascade = ^bus.cascade;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                act_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            pend_q <= '0;
            tc_q   <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // tc is a single-cycle pulse unless re-armed below.
                tc_q[i] <= 1'b0;

                // A write always lands in the shadow; branches that consume
                // the new modulus immediately clear pend afterwards.
                if (bus.max_wr[i]) begin
                    shadow_q[i] <= slice[i];
                    pend_q[i]   <= 1'b1;
                end

                if (bus.restart[i]) begin
                    act_q[i]  <= next_max[i];
                    pend_q[i] <= 1'b0;
                    cnt_q[i]  <= next_start[i];
                    done_q[i] <= 1'b0;
                end else if (term_step[i]) begin
                    tc_q[i] <= 1'b1;
                    if (bus.oneshot[i]) begin
                        // Hold at the terminal value; any shadow waits for restart.
                        done_q[i] <= 1'b1;
                    end else begin
                        act_q[i]  <= next_max[i];
                        pend_q[i] <= 1'b0;
                        cnt_q[i]  <= next_start[i];
                    end
                end else if (step[i]) begin
                    if (bus.dir[i]) begin
                        cnt_q[i] <= cnt_q[i] - 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign bus.cnt_value[g*WIDTH +: WIDTH] = cnt_q[g];
    end

    assign bus.tc   = tc_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_cnt_var_bank.sv
// Purpose : self-checking bench for cnt_var_bank (directed sequences plus randomized run vs reference model).
// Latency : inputs driven after the falling edge, outputs sampled one full cycle later.
// Backpressure: not applicable; the bench drives every channel freely.
module tb_cnt_var_bank;
    localparam int NCH = 2;
    localparam int W   = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    cnt_var_bank_if #(.NCH(NCH), .WIDTH(W)) bus ();

    cnt_var_bank #(.NCH(NCH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per channel, advanced once per clock from
    // the documented counting rules.
    logic [W-1:0] m_cnt  [NCH];
    logic [W-1:0] m_mod  [NCH];
    logic [W-1:0] m_sh   [NCH];
    logic         m_pend [NCH];
    logic         m_tc   [NCH];
    logic         m_done [NCH];

    function automatic logic [W-1:0] dut_cnt(input int ch);
        return bus.cnt_value[ch*W +: W];
    endfunction

    task automatic model_clock();
        logic chain;
        chain = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            int          modv, last, newm, start, cur;
            logic        adv, wrap;
            cur  = int'(m_cnt[i]);
            modv = int'(m_mod[i]);
            last = (modv <= 1) ? 0 : modv - 1;
            adv  = bus.en[i] && !m_done[i];
`ifdef CNT_CASCADE_EN
            if (i > 0 && bus.cascade[i]) adv = adv && chain;
`endif
            wrap  = adv && (bus.dir[i] ? (cur == 0) : (cur >= last));
            chain = wrap;
            if (bus.max_wr[i])   newm = int'(bus.max_value[i*W +: W]);
            else if (m_pend[i])  newm = int'(m_sh[i]);
            else                 newm = modv;
            start = bus.dir[i] ? ((newm <= 1) ? 0 : newm - 1) : 0;
            if (rst) begin
                m_cnt[i] = '0; m_mod[i] = '0; m_sh[i] = '0;
                m_pend[i] = 1'b0; m_tc[i] = 1'b0; m_done[i] = 1'b0;
                continue;
            end
            m_tc[i] = 1'b0;
            if (bus.max_wr[i]) begin
                m_sh[i]   = bus.max_value[i*W +: W];
                m_pend[i] = 1'b1;
            end
            if (bus.restart[i]) begin
                m_mod[i] = W'(newm); m_pend[i] = 1'b0; m_cnt[i] = W'(start);
                m_done[i] = 1'b0;
            end else if (wrap && bus.oneshot[i]) begin
                m_tc[i] = 1'b1; m_done[i] = 1'b1;
            end else if (wrap) begin
                m_tc[i] = 1'b1; m_mod[i] = W'(newm); m_pend[i] = 1'b0;
                m_cnt[i] = W'(start);
            end else if (adv) begin
                m_cnt[i] = W'(bus.dir[i] ? cur - 1 : cur + 1);
            end
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.en = '0; bus.dir = '0; bus.oneshot = '0; bus.max_value = '0;
        bus.max_wr = '0; bus.restart = '0; bus.cascade = '0;
    endtask

    // Write a modulus and restart the channel in the same cycle.
    task automatic load(input int ch, input int m, input logic d);
        bus.max_value[ch*W +: W] = W'(m);
        bus.dir[ch]     = d;
        bus.max_wr[ch]  = 1'b1;
        bus.restart[ch] = 1'b1;
        tick();
        bus.max_wr[ch]  = 1'b0;
        bus.restart[ch] = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        for (int ch = 0; ch < NCH; ch++) begin
            total++;
            if (dut_cnt(ch) !== 16'd0) begin
                bad++; $display("FAIL reset_cnt ch%0d got=%0d want=0", ch, dut_cnt(ch));
            end
            total++;
            if (bus.tc[ch] !== 1'b0 || bus.done[ch] !== 1'b0) begin
                bad++; $display("FAIL reset_flags ch%0d tc=%b done=%b want=0/0", ch, bus.tc[ch], bus.done[ch]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_up_mod5();
        clear_inputs();
        load(0, 5, 1'b0);
        total++;
        if (dut_cnt(0) !== 16'd0 || bus.tc[0] !== 1'b0) begin
            bad++; $display("FAIL up5_start got=%0d tc=%b want=0 tc=0", dut_cnt(0), bus.tc[0]);
        end
        bus.en[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (dut_cnt(0) !== 16'(k % 5) || bus.tc[0] !== (k % 5 == 0)) begin
                bad++; $display("FAIL up5_seq step%0d got=%0d tc=%b want=%0d tc=%b",
                                k, dut_cnt(0), bus.tc[0], k % 5, (k % 5 == 0));
            end
        end
        bus.en[0] = 1'b0;
    endtask

    task automatic test_down_mod4();
        int exp_c [7] = '{2, 1, 0, 3, 2, 3, 0};
        int exp_t [7] = '{0, 0, 0, 1, 0, 0, 1};
        clear_inputs();
        load(1, 4, 1'b1);
        total++;
        if (dut_cnt(1) !== 16'd3) begin
            bad++; $display("FAIL down4_start got=%0d want=3", dut_cnt(1));
        end
        bus.en[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) bus.dir[1] = 1'b0;   // flip to up while showing 2
            tick();
            total++;
            if (dut_cnt(1) !== 16'(exp_c[k]) || bus.tc[1] !== exp_t[k][0]) begin
                bad++; $display("FAIL down4_seq step%0d got=%0d tc=%b want=%0d tc=%0d",
                                k, dut_cnt(1), bus.tc[1], exp_c[k], exp_t[k]);
            end
        end
        bus.en[1] = 1'b0;
    endtask

    task automatic test_shadow();
        int exp_c [7] = '{2, 3, 4, 0, 1, 2, 0};
        int exp_t [7] = '{0, 0, 0, 1, 0, 0, 1};
        clear_inputs();
        load(0, 5, 1'b0);
        bus.en[0] = 1'b1;
        tick();                                   // now showing 1
        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin
                bus.max_value[0 +: W] = 16'd3;
                bus.max_wr[0] = 1'b1;
            end else begin
                bus.max_wr[0] = 1'b0;
            end
            tick();
            total++;
            if (dut_cnt(0) !== 16'(exp_c[k]) || bus.tc[0] !== exp_t[k][0]) begin
                bad++; $display("FAIL shadow_seq step%0d got=%0d tc=%b want=%0d tc=%0d",
                                k, dut_cnt(0), bus.tc[0], exp_c[k], exp_t[k]);
            end
        end
        bus.en[0] = 1'b0;
    endtask

    task automatic test_oneshot();
        int exp_c [5] = '{1, 2, 2, 2, 2};
        int exp_t [5] = '{0, 0, 1, 0, 0};
        int exp_d [5] = '{0, 0, 1, 1, 1};
        clear_inputs();
        bus.oneshot[0] = 1'b1;
        load(0, 3, 1'b0);
        bus.en[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (dut_cnt(0) !== 16'(exp_c[k]) || bus.tc[0] !== exp_t[k][0] || bus.done[0] !== exp_d[k][0]) begin
                bad++; $display("FAIL oneshot_seq step%0d got=%0d tc=%b done=%b want=%0d tc=%0d done=%0d",
                                k, dut_cnt(0), bus.tc[0], bus.done[0], exp_c[k], exp_t[k], exp_d[k]);
            end
        end
        bus.restart[0] = 1'b1;
        tick();
        bus.restart[0] = 1'b0;
        total++;
        if (dut_cnt(0) !== 16'd0 || bus.done[0] !== 1'b0 || bus.tc[0] !== 1'b0) begin
            bad++; $display("FAIL oneshot_restart got=%0d done=%b tc=%b want=0 done=0 tc=0",
                            dut_cnt(0), bus.done[0], bus.tc[0]);
        end
        tick();
        total++;
        if (dut_cnt(0) !== 16'd1) begin
            bad++; $display("FAIL oneshot_rerun got=%0d want=1", dut_cnt(0));
        end
        clear_inputs();
    endtask

    task automatic test_restart_wr_and_rst();
        clear_inputs();
        load(0, 5, 1'b0);
        bus.en[0] = 1'b1;
        tick();
        tick();
        bus.max_value[0 +: W] = 16'd7;
        bus.max_wr[0]  = 1'b1;
        bus.restart[0] = 1'b1;
        tick();
        bus.max_wr[0]  = 1'b0;
        bus.restart[0] = 1'b0;
        total++;
        if (dut_cnt(0) !== 16'd0 || bus.tc[0] !== 1'b0) begin
            bad++; $display("FAIL rstwr_start got=%0d tc=%b want=0 tc=0", dut_cnt(0), bus.tc[0]);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            total++;
            if (dut_cnt(0) !== 16'(k % 7) || bus.tc[0] !== (k == 7)) begin
                bad++; $display("FAIL rstwr_seq step%0d got=%0d tc=%b want=%0d tc=%b",
                                k, dut_cnt(0), bus.tc[0], k % 7, (k == 7));
            end
        end
        load(1, 9, 1'b0);
        bus.en[1] = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            total++;
            if (dut_cnt(ch) !== 16'd0 || bus.tc[ch] !== 1'b0 || bus.done[ch] !== 1'b0) begin
                bad++; $display("FAIL midrst ch%0d got=%0d tc=%b done=%b want=0/0/0",
                                ch, dut_cnt(ch), bus.tc[ch], bus.done[ch]);
            end
        end
        // Modulus was cleared too, so counting now fires tc every step at 0.
        bus.en[1] = 1'b0;
        tick();
        total++;
        if (dut_cnt(0) !== 16'd0 || bus.tc[0] !== 1'b1) begin
            bad++; $display("FAIL midrst_mod0 got=%0d tc=%b want=0 tc=1", dut_cnt(0), bus.tc[0]);
        end
        clear_inputs();
    endtask

    task automatic test_cascade();
        int n_tc1;
        int exp1;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.max_value = {16'd4, 16'd3};
        bus.max_wr  = 2'b11;
        bus.restart = 2'b11;
        tick();
        bus.max_wr  = 2'b00;
        bus.restart = 2'b00;
        bus.cascade = 2'b10;
        bus.en      = 2'b11;
        n_tc1 = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
`ifdef CNT_CASCADE_EN
            exp1 = (k / 3) % 4;
`else
            exp1 = k % 4;
`endif
            if (bus.tc[1] === 1'b1) n_tc1++;
            total++;
            if (dut_cnt(1) !== 16'(exp1)) begin
                bad++; $display("FAIL cascade_cnt1 step%0d got=%0d want=%0d", k, dut_cnt(1), exp1);
            end
`ifdef CNT_CASCADE_EN
            total++;
            if (bus.tc[1] === 1'b1 && bus.tc[0] !== 1'b1) begin
                bad++; $display("FAIL cascade_coinc step%0d tc1=%b tc0=%b want tc0=1", k, bus.tc[1], bus.tc[0]);
            end
`endif
        end
        total++;
`ifdef CNT_CASCADE_EN
        if (n_tc1 != 2) begin
            bad++; $display("FAIL cascade_tc1_count got=%0d want=2", n_tc1);
        end
`else
        if (n_tc1 != 6) begin
            bad++; $display("FAIL cascade_tc1_count got=%0d want=6", n_tc1);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_random();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int ch = 0; ch < NCH; ch++) begin
                bus.en[ch]      = ($urandom_range(0, 9) < 8);
                if ($urandom_range(0, 15) == 0) bus.dir[ch] = ~bus.dir[ch];
                if ($urandom_range(0, 31) == 0) bus.oneshot[ch] = ~bus.oneshot[ch];
                bus.max_wr[ch]  = ($urandom_range(0, 9) == 0);
                bus.restart[ch] = ($urandom_range(0, 24) == 0);
                bus.cascade[ch] = 1'($urandom_range(0, 1));
                bus.max_value[ch*W +: W] = 16'($urandom_range(0, 9));
            end
            tick();
            for (int ch = 0; ch < NCH; ch++) begin
                total++;
                if (dut_cnt(ch) !== m_cnt[ch]) begin
                    bad++; $display("FAIL rnd_cnt cyc%0d ch%0d got=%0d want=%0d", c, ch, dut_cnt(ch), m_cnt[ch]);
                end
                total++;
                if (bus.tc[ch] !== m_tc[ch] || bus.done[ch] !== m_done[ch]) begin
                    bad++; $display("FAIL rnd_flags cyc%0d ch%0d tc=%b done=%b want tc=%b done=%b",
                                    c, ch, bus.tc[ch], bus.done[ch], m_tc[ch], m_done[ch]);
                end
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = '0; m_mod[i] = '0; m_sh[i] = '0;
            m_pend[i] = 1'b0; m_tc[i] = 1'b0; m_done[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_up_mod5();
        test_down_mod4();
        test_shadow();
        test_oneshot();
        test_restart_wr_and_rst();
        test_cascade();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
